// File: rtl/od_bus_arbiter.sv
// Round-robin arbiter for a shared open-drain, wired-AND bus. Times the pull-down settle and
// the slower pull-up recovery with a counter, then samples the bus back and flags contention.
module od_bus_arbiter #(
  parameter int unsigned REQUESTERS  = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned FALL_CYCLES = 1,
  parameter int unsigned RISE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REQUESTERS-1:0]       req,
  input  logic [REQUESTERS*WIDTH-1:0] wdata,
  output logic [REQUESTERS-1:0]       grant,
  output logic [REQUESTERS-1:0]       done,
  output logic [WIDTH-1:0]            rdata,
  output logic                        err,
  output logic [WIDTH-1:0]            bus_pull,
  input  logic [WIDTH-1:0]            bus_in
);

  localparam int unsigned MaxCyc = (FALL_CYCLES > RISE_CYCLES) ? FALL_CYCLES : RISE_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned PtrW   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  localparam logic [CntW-1:0] FallLoad = CntW'(FALL_CYCLES - 1);
  localparam logic [CntW-1:0] RiseLoad = CntW'(RISE_CYCLES - 1);
  localparam logic [PtrW-1:0] PtrReset = PtrW'(REQUESTERS - 1);

  typedef enum logic [1:0] {
    StRecover,
    StIdle,
    StDrive,
    StRelease
  } state_e;

  state_e                  r_state,    w_state_nxt;
  logic [CntW-1:0]         r_cnt,      w_cnt_nxt;
  logic [PtrW-1:0]         r_rr_ptr,   w_rr_ptr_nxt;
  logic [REQUESTERS-1:0]   r_grant,    w_grant_nxt;
  logic [REQUESTERS-1:0]   r_done,     w_done_nxt;
  logic [WIDTH-1:0]        r_rdata,    w_rdata_nxt;
  logic                    r_err,      w_err_nxt;
  logic [WIDTH-1:0]        r_bus_pull, w_bus_pull_nxt;
  logic [WIDTH-1:0]        r_wlat,     w_wlat_nxt;

  logic                    w_found;
  logic [PtrW-1:0]         w_sel;
  logic [WIDTH-1:0]        w_word;

  function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % REQUESTERS;
    return PtrW'(s);
  endfunction

  // Search starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      if (!w_found && req[wrap_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_word = wdata[32'(w_sel)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_nxt    = r_grant;
    w_done_nxt     = '0;
    w_rdata_nxt    = r_rdata;
    w_err_nxt      = 1'b0;
    w_bus_pull_nxt = r_bus_pull;
    w_wlat_nxt     = r_wlat;

    unique case (r_state)
      StRecover, StRelease: begin
        w_bus_pull_nxt = '0;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end else begin
          w_state_nxt = StIdle;
          w_grant_nxt = '0;
        end
      end
      StIdle: begin
        if (w_found) begin
          w_grant_nxt    = REQUESTERS'(1) << w_sel;
          w_rr_ptr_nxt   = w_sel;
          w_wlat_nxt     = w_word;
          w_bus_pull_nxt = ~w_word;
          w_cnt_nxt      = FallLoad;
          w_state_nxt    = StDrive;
        end
      end
      StDrive: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end else begin
          w_rdata_nxt    = bus_in;
          w_done_nxt     = r_grant;
          w_err_nxt      = (bus_in != r_wlat);
          w_bus_pull_nxt = '0;
          w_cnt_nxt      = RiseLoad;
          w_state_nxt    = StRelease;
        end
      end
      default: begin
        w_state_nxt    = StRecover;
        w_bus_pull_nxt = '0;
        w_grant_nxt    = '0;
        w_cnt_nxt      = RiseLoad;
      end
    endcase
  end

  // Async reset also drops the pull-downs immediately so a stuck-low bus is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StRecover;
      r_cnt      <= RiseLoad;
      r_rr_ptr   <= PtrReset;
      r_grant    <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_bus_pull <= '0;
      r_wlat     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
      r_bus_pull <= w_bus_pull_nxt;
      r_wlat     <= w_wlat_nxt;
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign err      = r_err;
  assign bus_pull = r_bus_pull;

endmodule

// File: tb/tb_od_bus_arbiter.sv
// Bench for od_bus_arbiter: two instances (default timing and FALL=3/RISE=2) checked against a
// transaction-level round-robin and wired-AND bus model.
module tb_od_bus_arbiter;

  localparam int FallA = 1;
  localparam int RiseA = 4;
  localparam int FallB = 3;
  localparam int RiseB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        use_b;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [7:0]  other_m;
  logic [7:0]  open_m;

  logic [3:0] req_a, grant_a, done_a, req_b, grant_b, done_b;
  logic [7:0] rdata_a, pull_a, bus_in_a, rdata_b, pull_b, bus_in_b;
  logic       err_a, err_b;

  logic [3:0] o_grant, o_done;
  logic [7:0] o_rdata, o_pull;
  logic       o_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_g = 0;
  int rr_m [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wired-AND bus: a bit reads low if our enabled pull-down works or another driver pulls it.
  assign bus_in_a = ~((pull_a & ~open_m) | other_m);
  assign bus_in_b = ~((pull_b & ~open_m) | other_m);
  assign req_a    = use_b ? 4'b0 : req;
  assign req_b    = use_b ? req : 4'b0;

  assign o_grant = use_b ? grant_b : grant_a;
  assign o_done  = use_b ? done_b  : done_a;
  assign o_rdata = use_b ? rdata_b : rdata_a;
  assign o_pull  = use_b ? pull_b  : pull_a;
  assign o_err   = use_b ? err_b   : err_a;

  od_bus_arbiter #(.REQUESTERS(4), .WIDTH(8), .FALL_CYCLES(FallA), .RISE_CYCLES(RiseA)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .wdata(wdata), .grant(grant_a), .done(done_a),
    .rdata(rdata_a), .err(err_a), .bus_pull(pull_a), .bus_in(bus_in_a)
  );

  od_bus_arbiter #(.REQUESTERS(4), .WIDTH(8), .FALL_CYCLES(FallB), .RISE_CYCLES(RiseB)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .wdata(wdata), .grant(grant_b), .done(done_b),
    .rdata(rdata_b), .err(err_b), .bus_pull(pull_b), .bus_in(bus_in_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester after the previous winner, wrapping around.
  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rr_m[0] = 3;
    rr_m[1] = 3;
  endtask

  task automatic do_txn(input int exp_wait, input bit chk_period, input bit mutate,
                        input logic [3:0] req_after, input string tag);
    int n, sel, fall, rise;
    logic [7:0] wd, exp_pull, exp_rd;
    logic       exp_err;
    fall = use_b ? FallB : FallA;
    rise = use_b ? RiseB : RiseA;
    sel  = pick(req, rr_m[use_b]);
    n = 0;
    while (o_grant == 4'b0 && n < 50) begin
      tick();
      n++;
    end
    if (exp_wait >= 0) check({tag, ":wait"}, n, exp_wait);
    check({tag, ":grant"}, o_grant, 1 << sel);
    wd       = wdata[sel*8 +: 8];
    exp_pull = ~wd;
    check({tag, ":pull"}, o_pull, exp_pull);
    if (chk_period) check({tag, ":period"}, cyc - last_g, fall + rise + 1);
    last_g = cyc;
    rr_m[use_b] = sel;
    exp_rd  = ~((exp_pull & ~open_m) | other_m);
    exp_err = (exp_rd != wd);
    if (mutate) begin
      req   = req_after;
      wdata = ~wdata;
    end
    n = 0;
    while (o_done == 4'b0 && n < 50) begin
      tick();
      n++;
      if (o_done == 4'b0 && n < fall) check({tag, ":hold"}, o_pull, exp_pull);
    end
    check({tag, ":lat"}, n, fall);
    check({tag, ":done"}, o_done, 1 << sel);
    check({tag, ":gheld"}, o_grant, 1 << sel);
    check({tag, ":rdata"}, o_rdata, exp_rd);
    check({tag, ":err"}, o_err, exp_err);
    check({tag, ":rel"}, o_pull, 0);
    tick();
    n = 1;
    check({tag, ":done1"}, o_done, 0);
    check({tag, ":err1"}, o_err, 0);
    check({tag, ":rhold"}, o_rdata, exp_rd);
    while (o_grant != 4'b0 && n < 50) begin
      tick();
      n++;
    end
    check({tag, ":gdrop"}, n, rise);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    use_b   = 1'b0;
    req     = 4'b0001;
    wdata   = 32'h000000A5;
    other_m = 8'h00;
    open_m  = 8'h00;
    rr_m[0] = 3;
    rr_m[1] = 3;
    #1;
    check("rst:grant", grant_a, 0);
    check("rst:pull_a", pull_a, 0);
    tick();
    tick();
    check("rst:done", done_a, 0);
    check("rst:err", err_a, 0);
    check("rst:rdata", rdata_a, 0);
    check("rst:pull_b", pull_b, 0);
    rst_n = 1'b1;
    do_txn(RiseA + 1, 0, 0, 4'b0, "basic");

    do_reset();
    req   = 4'b1111;
    wdata = $urandom;
    do_txn(RiseA + 1, 0, 0, 4'b0, "rr0");
    for (int i = 1; i < 5; i++) do_txn(1, 1, 0, 4'b0, "rr");

    req         = 4'b0010;
    wdata[15:8] = 8'hFF;
    other_m     = 8'h01;
    do_txn(1, 0, 0, 4'b0, "contend");
    other_m      = 8'h00;
    req          = 4'b1000;
    wdata[31:24] = 8'h0F;
    open_m       = 8'h80;
    do_txn(1, 0, 0, 4'b0, "open");
    open_m = 8'h00;

    req = 4'b0100;
    do_txn(1, 0, 1, 4'b0001, "drop");
    do_txn(1, 1, 0, 4'b0, "after_drop");

    for (int i = 0; i < 16; i++) begin
      req     = 4'($urandom_range(1, 15));
      wdata   = $urandom;
      other_m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      open_m  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      do_txn(1, 1, 0, 4'b0, "rand_a");
    end
    other_m = 8'h00;
    open_m  = 8'h00;

    use_b = 1'b1;
    req   = 4'b0001;
    wdata = $urandom;
    do_txn(1, 0, 1, 4'b0001, "b_mut");
    for (int i = 0; i < 3; i++) begin
      req   = 4'($urandom_range(1, 15));
      wdata = $urandom;
      do_txn(1, 1, 0, 4'b0, "rand_b");
    end

    req = 4'b0001;
    n = 0;
    while (grant_b == 4'b0 && n < 50) begin
      tick();
      n++;
    end
    check("mrst:grant", grant_b, 4'b0001);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst:pull", pull_b, 0);
    check("mrst:grant0", grant_b, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst:nodone", done_b, 0);
    end
    rst_n   = 1'b1;
    rr_m[0] = 3;
    rr_m[1] = 3;
    do_txn(RiseB + 1, 0, 0, 4'b0, "b_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
